// File: rtl/pilha_pkg.sv
// Shared types for the Forth return-stack controller: command codes,
// sequencer states and requester identifiers.
package pilha_pkg;

   typedef enum logic [1:0] {
      OP_PUSH = 2'b00,
      OP_POP  = 2'b01,
      OP_PEEK = 2'b10,
      OP_DROP = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_ACK  = 2'b10
   } state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_IRQ = 1'b1
   } req_id_t;

endpackage

// File: rtl/pilha_ram.sv
// Single-clock return-stack storage: one write port, one registered read port.
module pilha_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/controle_pilha_retorno.sv
// Return-stack sequencer: arbitrates CPU and interrupt requests, owns the
// stack pointer and runs one PUSH/POP/PEEK/DROP per three-cycle transaction.
module controle_pilha_retorno
   import pilha_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cpu_req,
   input  logic [1:0]            cpu_op,
   input  logic [DATA_WIDTH-1:0] cpu_data,
   output logic                  cpu_ack,
   input  logic                  irq_req,
   input  logic [1:0]            irq_op,
   input  logic [DATA_WIDTH-1:0] irq_data,
   output logic                  irq_ack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH:0]   depth,
   output logic                  empty,
   output logic                  full,
   output logic                  busy,
   output logic                  err_overflow,
   output logic                  err_underflow,
   input  logic                  err_clear
);

   localparam logic [ADDR_WIDTH:0] DEPTH_MAX = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);

   state_t                state, state_nxt;
   req_id_t               grant, grant_nxt, last_grant;
   op_t                   op_lat;
   logic [DATA_WIDTH-1:0] data_lat;
   logic [ADDR_WIDTH:0]   depth_r;
   logic                  rd_valid, resp_q;
   logic                  any_req, is_push, is_read, is_pop_like;
   logic                  err_ov, err_un, do_write, do_read;
   logic [ADDR_WIDTH-1:0] waddr, raddr;
   logic [DATA_WIDTH-1:0] ram_q;

   assign any_req = cpu_req | irq_req;

   // Round-robin only matters on a tie; a lone requester always wins.
   always_comb begin
      grant_nxt = REQ_CPU;
      if (cpu_req && irq_req)
         grant_nxt = (last_grant == REQ_CPU) ? REQ_IRQ : REQ_CPU;
      else if (irq_req)
         grant_nxt = REQ_IRQ;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (any_req) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = ST_ACK;
         ST_ACK:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cpu_ack = (state == ST_ACK) && (grant == REQ_CPU);
      irq_ack = (state == ST_ACK) && (grant == REQ_IRQ);
      busy    = (state != ST_IDLE);
   end

   assign empty       = (depth_r == '0);
   assign full        = (depth_r == DEPTH_MAX);
   assign depth       = depth_r;
   assign is_push     = (op_lat == OP_PUSH);
   assign is_read     = (op_lat == OP_POP) || (op_lat == OP_PEEK);
   assign is_pop_like = (op_lat == OP_POP) || (op_lat == OP_DROP);
   assign err_ov      = is_push && full;
   assign err_un      = !is_push && empty;
   assign do_write    = (state == ST_EXEC) && is_push && !full;
   assign do_read     = (state == ST_EXEC) && is_read && !empty;
   assign waddr       = depth_r[ADDR_WIDTH-1:0];
   assign raddr       = ADDR_WIDTH'(depth_r - ONE);

   // Winner's command is captured at grant; later input changes are ignored.
   always_ff @(posedge clock) begin
      if (state == ST_IDLE && any_req) begin
         op_lat   <= (grant_nxt == REQ_IRQ) ? op_t'(irq_op) : op_t'(cpu_op);
         data_lat <= (grant_nxt == REQ_IRQ) ? irq_data : cpu_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         grant         <= REQ_IRQ;
         last_grant    <= REQ_IRQ;
         depth_r       <= '0;
         rd_valid      <= 1'b0;
         resp_q        <= 1'b0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (state == ST_IDLE && any_req) begin
            grant      <= grant_nxt;
            last_grant <= grant_nxt;
         end
         if (state == ST_EXEC) begin
            resp_q   <= err_ov | err_un;
            rd_valid <= do_read;
            if (is_push && !full)
               depth_r <= depth_r + ONE;
            else if (is_pop_like && !empty)
               depth_r <= depth_r - ONE;
         end else begin
            resp_q   <= 1'b0;
            rd_valid <= 1'b0;
         end
         // A new error in the same cycle as err_clear must survive.
         err_overflow  <= (err_overflow  & ~err_clear) | ((state == ST_EXEC) & err_ov);
         err_underflow <= (err_underflow & ~err_clear) | ((state == ST_EXEC) & err_un);
      end
   end

   assign resp_err = resp_q;
   assign rdata    = rd_valid ? ram_q : '0;

   pilha_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clock (clock),
      .we    (do_write),
      .waddr (waddr),
      .wdata (data_lat),
      .re    (do_read),
      .raddr (raddr),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_controle_pilha_retorno.sv
// Randomized and directed bench for controle_pilha_retorno against a queue-based stack model.
module tb_controle_pilha_retorno;

   localparam int DW    = 16;
   localparam int AW    = 2;
   localparam int DEPTH = 2**AW;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          cpu_req, irq_req, cpu_ack, irq_ack;
   logic [1:0]    cpu_op, irq_op;
   logic [DW-1:0] cpu_data, irq_data, rdata;
   logic          resp_err, empty, full, busy;
   logic          err_overflow, err_underflow, err_clear;
   logic [AW:0]   depth;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int q[$];
   bit last_irq;
   bit m_ov, m_un;

   always #5 clock = ~clock;

   controle_pilha_retorno #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .cpu_req       (cpu_req),
      .cpu_op        (cpu_op),
      .cpu_data      (cpu_data),
      .cpu_ack       (cpu_ack),
      .irq_req       (irq_req),
      .irq_op        (irq_op),
      .irq_data      (irq_data),
      .irq_ack       (irq_ack),
      .rdata         (rdata),
      .resp_err      (resp_err),
      .depth         (depth),
      .empty         (empty),
      .full          (full),
      .busy          (busy),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow),
      .err_clear     (err_clear)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_status(input string tag);
      check_val({tag, ".depth"}, depth, q.size());
      check_val({tag, ".empty"}, empty, q.size() == 0);
      check_val({tag, ".full"},  full,  q.size() == DEPTH);
      check_val({tag, ".ovf"},   err_overflow,  m_ov);
      check_val({tag, ".unf"},   err_underflow, m_un);
   endtask

   // Issues commands from one or both requesters; clr raises err_clear on the first command's execute edge.
   task automatic run_cmds(input bit c_en, input bit i_en, input bit [1:0] c_op, input bit [1:0] i_op,
                           input logic [DW-1:0] c_d, input logic [DW-1:0] i_d, input bit clr);
      bit       pend[2];
      bit       w, exp_err, clr_now;
      bit [1:0] op;
      int       d, exp_rd;
      @(negedge clock);
      cpu_req = c_en; cpu_op = c_op; cpu_data = c_d;
      irq_req = i_en; irq_op = i_op; irq_data = i_d;
      pend[0] = c_en; pend[1] = i_en;
      clr_now = clr;
      while (pend[0] || pend[1]) begin
         if (pend[0] && pend[1]) w = last_irq ? 1'b0 : 1'b1;
         else                    w = pend[1];
         last_irq = w;
         op = w ? i_op : c_op;
         d  = w ? int'(i_d) : int'(c_d);
         exp_err = 1'b0;
         exp_rd  = 0;
         case (op)
            2'b00: if (q.size() == DEPTH) exp_err = 1'b1; else q.push_back(d);
            2'b01: if (q.size() == 0) exp_err = 1'b1; else exp_rd = q.pop_back();
            2'b10: if (q.size() == 0) exp_err = 1'b1; else exp_rd = q[$];
            default: if (q.size() == 0) exp_err = 1'b1; else void'(q.pop_back());
         endcase
         if (clr_now) begin m_ov = 1'b0; m_un = 1'b0; end
         if (exp_err && op == 2'b00) m_ov = 1'b1;
         if (exp_err && op != 2'b00) m_un = 1'b1;
         @(posedge clock); @(negedge clock);
         check_val("exec.busy", busy, 1);
         check_val("exec.acks", {cpu_ack, irq_ack}, 0);
         if (clr_now) err_clear = 1'b1;
         @(posedge clock); @(negedge clock);
         err_clear = 1'b0;
         clr_now   = 1'b0;
         check_val("ack.cpu", cpu_ack, !w);
         check_val("ack.irq", irq_ack, w);
         check_val("ack.err", resp_err, exp_err);
         if (op != 2'b00) check_val("ack.rdata", rdata, exp_rd);
         check_status("ack");
         if (w) irq_req = 1'b0; else cpu_req = 1'b0;
         pend[w] = 1'b0;
         @(posedge clock); @(negedge clock);
         check_val("idle.busy", busy, 0);
         check_val("idle.acks", {cpu_ack, irq_ack}, 0);
      end
   endtask

   task automatic clear_pulse();
      @(negedge clock); err_clear = 1'b1;
      @(negedge clock); err_clear = 1'b0;
      m_ov = 1'b0; m_un = 1'b0;
      check_status("clr");
   endtask

   task automatic model_reset();
      q.delete();
      last_irq = 1'b1;
      m_ov = 1'b0; m_un = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; err_clear = 1'b0;
      cpu_req = 1'b0; cpu_op = 2'b00; cpu_data = '0;
      irq_req = 1'b0; irq_op = 2'b00; irq_data = '0;
      model_reset();
      repeat (2) @(negedge clock);
      check_val("rst.busy",  busy, 0);
      check_val("rst.acks",  {cpu_ack, irq_ack}, 0);
      check_val("rst.rdata", rdata, 0);
      check_val("rst.err",   resp_err, 0);
      check_status("rst");
      reset_n = 1'b1;

      // Tie right after reset: CPU first, then IRQ; pops come back LIFO
      run_cmds(1, 1, 2'b00, 2'b00, 16'hAAAA, 16'h5555, 0);
      run_cmds(1, 0, 2'b01, 2'b00, 16'h0, 16'h0, 0);
      run_cmds(0, 1, 2'b01, 2'b00, 16'h0, 16'h0, 0);
      run_cmds(1, 0, 2'b00, 2'b00, 16'h1234, 16'h0, 0);
      run_cmds(1, 0, 2'b01, 2'b00, 16'h0, 16'h0, 0);

      // Fill to capacity, overflow, peek top
      for (int i = 0; i < DEPTH + 1; i++)
         run_cmds(i[0], !i[0], 2'b00, 2'b00, DW'(16'h100 + i), DW'(16'h200 + i), 0);
      run_cmds(1, 0, 2'b10, 2'b00, 16'h0, 16'h0, 0);
      run_cmds(0, 1, 2'b11, 2'b00, 16'h0, 16'h0, 0);
      run_cmds(1, 0, 2'b10, 2'b00, 16'h0, 16'h0, 0);
      for (int i = 0; i < DEPTH; i++)
         run_cmds(1, 0, 2'b01, 2'b00, 16'h0, 16'h0, 0);
      clear_pulse();

      // Underflow, clear, then clear colliding with a fresh underflow
      run_cmds(1, 0, 2'b01, 2'b00, 16'h0, 16'h0, 0);
      clear_pulse();
      run_cmds(0, 1, 2'b11, 2'b11, 16'h0, 16'h0, 1);

      // Reset while a PUSH is executing
      @(negedge clock);
      cpu_req = 1'b1; cpu_op = 2'b00; cpu_data = 16'hBEEF;
      @(posedge clock); @(negedge clock);
      reset_n = 1'b0;
      #1;
      cpu_req = 1'b0;
      model_reset();
      check_val("mid.busy", busy, 0);
      check_val("mid.acks", {cpu_ack, irq_ack}, 0);
      check_status("mid");
      @(negedge clock); reset_n = 1'b1;
      @(posedge clock); @(negedge clock);
      check_val("mid.post_busy", busy, 0);
      check_val("mid.post_ack", cpu_ack, 0);

      // Randomized mix
      for (int n = 0; n < 300; n++) begin
         int  who;
         bit  c_en, i_en;
         who  = $urandom_range(0, 3);
         c_en = (who == 0) || (who == 2);
         i_en = (who == 1) || (who == 2) || (who == 3 && $urandom_range(0, 1) == 1);
         if (!c_en && !i_en) c_en = 1'b1;
         run_cmds(c_en, i_en, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  DW'($urandom), DW'($urandom), $urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) clear_pulse();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/controle_pilha_retorno.md
# controle_pilha_retorno

Sequencer and arbiter for the Forth return stack: owns the stack pointer and a single-clock stack RAM, and serves PUSH/POP/PEEK/DROP commands from two requesters (CPU core for CALL/RET/>R/R>, interrupt unit for entry/RETI) over req/ack handshakes. It replaces direct, free-running pointer updates with an explicit FSM, bounds-checked depth, and sticky error flags. It sits between the instruction decoder/interrupt unit and the return-stack storage.

## Interface
- DATA_WIDTH, 16, stack word width
- ADDR_WIDTH, 10, RAM address width; capacity DEPTH = 2**ADDR_WIDTH words
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_op  in  2  CPU command (PUSH/POP/PEEK/DROP)
- cpu_data  in  DATA_WIDTH  CPU push data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- irq_req  in  1  interrupt-unit request, held until irq_ack
- irq_op  in  2  interrupt-unit command
- irq_data  in  DATA_WIDTH  interrupt-unit push data
- irq_ack  out  1  one-cycle completion pulse to interrupt unit
- rdata  out  DATA_WIDTH  popped/peeked word, valid while either ack is high
- resp_err  out  1  high with ack when the command was rejected
- depth  out  ADDR_WIDTH+1  current word count, 0..DEPTH
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- busy  out  1  FSM not in IDLE
- err_overflow  out  1  sticky: PUSH attempted while full
- err_underflow  out  1  sticky: POP/PEEK/DROP attempted while empty
- err_clear  in  1  synchronous clear of both sticky flags

## Operation
- FSM states: IDLE, EXEC, ACK. IDLE -> EXEC when any req sampled high; EXEC -> ACK unconditionally; ACK -> IDLE unconditionally.
- Arbitration in IDLE: one requester high -> grant it; both high -> round-robin, grant the one not granted last. last_grant resets to IRQ, so CPU wins the first tie.
- At grant, op and data of the winner are latched; requester inputs are ignored until IDLE.
- PUSH: not full -> ram[depth mod DEPTH] <= data, depth+1. Full -> no write, depth unchanged, resp_err=1, err_overflow set.
- POP: not empty -> rdata = ram[depth-1], depth-1. Empty -> rdata=0, resp_err=1, err_underflow set.
- PEEK: as POP, depth unchanged.
- DROP: as POP without data; rdata=0.
- Addresses are the low ADDR_WIDTH bits of depth/depth-1; depth itself never wraps (saturating checks above).
- err_clear and a new error in the same cycle: set wins.
- Only the granted requester's ack pulses; the other ack stays 0.

## Timing
- Reset values: cpu_ack=0, irq_ack=0, rdata=0, resp_err=0, depth=0, empty=1, full=0, busy=0, both err flags 0, state IDLE, last_grant=IRQ. RAM contents not cleared.
- Edge E0: IDLE samples req, grants, latches. Edge E1: EXEC performs RAM write or issues registered read, updates depth. Cycle after E1 (state ACK): ack=1, rdata/resp_err valid. Edge E2: back to IDLE.
- Latency: ack visible 2 edges after req first sampled; throughput one command per 3 cycles.
- Requester must drop req in the ack cycle; req still high at IDLE after E2 is a new command.
- depth/empty/full update at E1, visible during the ack cycle.
- reset_n low mid-command: immediate return to reset values; in-flight command abandoned, no ack.

## Structure
- Shared package pilha_pkg: op codes OP_PUSH=2'b00, OP_POP=2'b01, OP_PEEK=2'b10, OP_DROP=2'b11; FSM state typedef; requester-id typedef (REQ_CPU, REQ_IRQ).
- Sub-module pilha_ram: single-clock RAM, one write port, registered read port, parameterized by DATA_WIDTH/ADDR_WIDTH.

## Test plan
- Reset, CPU PUSH 0x1234 then POP -> cpu_ack at 2nd edge each, rdata=0x1234, depth 1 then 0, resp_err=0.
- Both req high in same cycle, PUSH 0xAAAA (cpu) / PUSH 0x5555 (irq) -> CPU acked first, IRQ next; POP twice returns 0x5555, 0xAAAA.
- ADDR_WIDTH=2: 4 PUSHes -> full=1; 5th PUSH -> resp_err=1, err_overflow=1, depth stays 4; PEEK returns 4th word.
- POP on empty -> rdata=0, resp_err=1, err_underflow=1; err_clear pulse -> flag 0; err_clear with DROP-on-empty same cycle -> flag stays 1.
- PEEK leaves depth unchanged; DROP decrements depth with rdata=0.
- reset_n low during EXEC of PUSH -> no ack, depth=0, busy=0, state IDLE after release.
